// File: rtl/dmem_mmio_responder.sv
// Data-port responder: word RAM, MMIO TX byte FIFO, cycle counter and status register.
// Optional DMEM_ACC_ERR_EN: suppress misaligned/unmapped stores, pulse acc_err, DEADBEEF on unmapped reads.
module dmem_mmio_responder #(
    parameter int          ADDR_W          = 8,
    parameter int          FIFO_DEPTH_LOG2 = 3,
    parameter logic [15:0] MMIO_PAGE       = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_out,
    input  logic        data_wr,
    output logic [31:0] data_in,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        acc_err
);
    localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [15:0] OFF_TX  = 16'h0000;
    localparam logic [15:0] OFF_ST  = 16'h0004;
    localparam logic [15:0] OFF_CYC = 16'h0008;
    localparam logic [15:0] OFF_CNT = 16'h000C;

    logic [31:0]                ram  [2**ADDR_W];
    logic [7:0]                 fifo [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] head, tail;
    logic [CNT_W-1:0]           count;
    logic                       ovf;
    logic [31:0]                cycle;

    logic              is_mmio, mapped, wr_ok;
    logic              empty, full, pop, tx_wr, push, ovf_set, ovf_clr, cyc_ld;
    logic [15:0]       off;
    logic [ADDR_W-1:0] idx;

    assign is_mmio = (data_addr[31:16] == MMIO_PAGE);
    assign off     = data_addr[15:0];
    assign idx     = data_addr[ADDR_W+1:2];
    assign mapped  = (off == OFF_TX) || (off == OFF_ST) || (off == OFF_CYC) || (off == OFF_CNT);

`ifdef DMEM_ACC_ERR_EN
    localparam logic [31:0] UNMAPPED_RD = 32'hDEADBEEF;
    logic err;
    assign err   = data_wr && ((data_addr[1:0] != 2'b00) || (is_mmio && !mapped));
    assign wr_ok = data_wr && !err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_err <= 1'b0;
        else        acc_err <= err;
    end
`else
    localparam logic [31:0] UNMAPPED_RD = 32'h0;
    assign wr_ok   = data_wr;
    assign acc_err = 1'b0;
`endif

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign tx_valid = !empty;
    assign tx_data  = fifo[head];
    assign pop      = tx_valid && tx_ready;
    assign tx_wr    = wr_ok && is_mmio && (off == OFF_TX);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push     = tx_wr && (!full || pop);
    assign ovf_set  = tx_wr && full && !pop;
    assign ovf_clr  = wr_ok && is_mmio && (off == OFF_ST) && data_out[2];
    assign cyc_ld   = wr_ok && is_mmio && (off == OFF_CYC);

    always_comb begin
        data_in = '0;
        if (!is_mmio) begin
            data_in = ram[idx];
        end else begin
            case (off)
                OFF_TX:  data_in = '0;
                OFF_ST:  data_in = {29'b0, ovf, full, empty};
                OFF_CYC: data_in = cycle;
                OFF_CNT: data_in = {{(32-CNT_W){1'b0}}, count};
                default: data_in = UNMAPPED_RD;
            endcase
        end
    end

    // Storage arrays carry no reset; only pointers and counters do.
    always_ff @(posedge clk) begin
        if (wr_ok && !is_mmio) ram[idx] <= data_out;
        if (push)              fifo[tail] <= data_out[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ovf   <= 1'b0;
            cycle <= '0;
        end else begin
            if (push) tail <= tail + FIFO_DEPTH_LOG2'(1);
            if (pop)  head <= head + FIFO_DEPTH_LOG2'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (ovf_set)      ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
            if (cyc_ld) cycle <= data_out;
            else        cycle <= cycle + 32'd1;
        end
    end
endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Data-memory responder for the pipelined core's data port. It answers `data_addr`, `data_out` and `data_wr` from the MEM stage.
- Provides a word RAM, a memory-mapped byte TX FIFO with a valid/ready drain port, a free-running cycle counter and a status register.
- Read data is combinational so the core can latch it into MEM/WB in the same cycle. Writes commit on the clock edge.

Parameters:
- `ADDR_W`, 8: log2 of RAM depth in 32-bit words (256 words).
- `FIFO_DEPTH_LOG2`, 3: log2 of TX FIFO depth (8 entries).
- `MMIO_PAGE`, 16'hFFFF: value of `addr[31:16]` that selects the MMIO region.

Ports:
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `data_addr`, input, 32: byte address from the core.
- `data_out`, input, 32: store data from the core.
- `data_wr`, input, 1: store strobe from the core.
- `data_in`, output, 32: load data to the core (combinational).
- `tx_data`, output, 8: FIFO head byte.
- `tx_valid`, output, 1: FIFO not empty.
- `tx_ready`, input, 1: downstream consumer accepts the head byte.
- `acc_err`, output, 1: registered one-cycle pulse on an access error.

Behaviour:
- Decode:
  - MMIO when `data_addr[31:16] == MMIO_PAGE`; otherwise RAM.
  - RAM word index is `data_addr[ADDR_W+1:2]`. Higher bits are ignored, so addresses alias and wrap modulo the RAM size.
- RAM:
  - Read is combinational: `data_in = mem[idx]`.
  - Write on posedge when `data_wr` is high. Full 32-bit word only, no byte enables.
  - Contents are not reset.
  - A same-cycle read of the word being written returns the old value.
- MMIO map (offset = `data_addr[15:0]`):
  - 0x0000 TX_DATA
    - Write: push `data_out[7:0]` into the FIFO.
    - Read: returns 0.
  - 0x0004 STATUS
    - Read: `{29'b0, ovf, full, empty}`.
    - Write with `data_out[2]=1`: clears `ovf`. Other bits are ignored.
  - 0x0008 CYCLE
    - Read: current counter value.
    - Write: loads `data_out`. The load has priority over the increment that cycle.
  - 0x000C COUNT
    - Read: `{(32-FIFO_DEPTH_LOG2-1)'b0, count}`.
    - Write: ignored.
  - Any other offset: read returns 0, write is ignored (see optional feature).
- TX FIFO:
  - `count` is FIFO_DEPTH_LOG2+1 bits wide. `empty = (count==0)`, `full = (count==2^FIFO_DEPTH_LOG2)`.
  - Head/tail pointers wrap modulo the depth.
  - `tx_valid = !empty`, `tx_data = mem[head]`. `tx_data` holds its value while `tx_valid && !tx_ready`.
  - Pop when `tx_valid && tx_ready`.
  - Push when a TX_DATA write occurs and (`!full` or a pop happens the same cycle). A push and pop in the same cycle leave `count` unchanged.
  - A push while full with no pop is dropped and sets sticky `ovf` (1 thereafter until cleared).
  - If an `ovf` clear and a new overflow occur in the same cycle, the overflow wins and `ovf` stays 1.
- CYCLE counter: increments by 1 every clock after reset and wraps 0xFFFFFFFF to 0.
- Reset values (async):
  - head=0, tail=0, count=0, `ovf`=0, CYCLE=0, `acc_err`=0.
  - Hence `tx_valid`=0 and `tx_data`=FIFO mem[0] (don't care).
  - Reset mid-drain discards all queued bytes immediately.
- Latency:
  - Loads: 0 cycles.
  - Stores: visible on the cycle after the edge.
  - A TX_DATA push makes `tx_valid` rise on the next cycle when the FIFO was empty.

Optional Feature:
- Macro: `DMEM_ACC_ERR_EN`.
- Defined: the checks run only while `data_wr` is high.
  - A store with `data_addr[1:0]!=0` is suppressed (no RAM or MMIO side effect).
  - A store to an unmapped MMIO offset is also suppressed (unmapped writes are ignored either way).
  - In both cases `acc_err` pulses high for exactly one cycle after the edge.
  - An unmapped MMIO read returns 32'hDEADBEEF.
- Not defined:
  - `acc_err` is tied to 0.
  - `data_addr[1:0]` is ignored and misaligned stores proceed to the aligned word.
  - Unmapped MMIO reads return 0.

Test Plan:
- Write 0x12345678 to 0x00000010, then read 0x00000010 and 0x00000410 (alias for `ADDR_W=8`) → both return 0x12345678.
- Hold `tx_ready`=0 and write bytes 0x41..0x49 (9 stores) to 0xFFFF0000 → COUNT=8, STATUS=0x6 (`ovf`, `full`). Raise `tx_ready` → `tx_data` sequence is 0x41..0x48, then `tx_valid`=0 and STATUS=0x5. Write 0x4 to STATUS → STATUS=0x1.
- With the FIFO full and `tx_ready`=1, write 0x5A to TX_DATA in the same cycle → COUNT stays 8, `ovf` stays 0, 0x5A is the last byte drained.
- Write 0xFFFFFFFE to 0xFFFF0008, wait 3 cycles, read → 0x00000001 (wrap verified).
- Assert `rst_n`=0 mid-drain with COUNT=5 → `tx_valid`=0, COUNT=0 and CYCLE=0 immediately, without waiting for a clock edge.
- With `DMEM_ACC_ERR_EN` defined, store 0xAAAAAAAA to 0x00000022 → word 0x00000020 unchanged, `acc_err` high for exactly 1 cycle. Read 0xFFFF0040 → 0xDEADBEEF.
